traffic_light_top: RTL and testbench

//   Main-street/side-street traffic light controller with pedestrian walk phase.

---
 rtl/tlc_pkg.sv | 28 ++
 rtl/tlc_timer.sv | 42 ++++
 rtl/traffic_light_top.sv | 161 ++++++++++++++++
 tb/tb_traffic_light_top.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared state encoding, interval selector codes and default intervals for the
// traffic light controller.
package tlc_pkg;

  typedef enum logic [2:0] {
    MG_BASE = 3'd0,
    MG_EXT  = 3'd1,
    MY      = 3'd2,
    WALK    = 3'd3,
    SG      = 3'd4,
    SG_EXT  = 3'd5,
    SY      = 3'd6
  } tlc_state_t;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;

  localparam logic [3:0] T_BASE_DEF = 4'd6;
  localparam logic [3:0] T_EXT_DEF  = 4'd3;
  localparam logic [3:0] T_YEL_DEF  = 4'd2;

  // A zero-second interval would never expire, so it runs as one second.
  function automatic logic [3:0] eff_interval(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

endpackage

// File: rtl/tlc_timer.sv
// Free-running 1-s tick divider plus a seconds down-counter reloaded by i_start;
// o_expired pulses on the tick that takes the count from 1 to 0.
module tlc_timer
  import tlc_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [3:0] i_interval,
  output logic       o_tick,
  output logic       o_expired
);

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] r_div;
  logic [3:0]    r_cnt;
  logic          w_tick;

  assign w_tick = (r_div == DIV_LAST) && !i_reset;
  assign o_tick = w_tick;
  // A tick landing on the load cycle is dropped, so each state gets its full interval.
  assign o_expired = w_tick && !i_start && (r_cnt == 4'd1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div <= '0;
      r_cnt <= '0;
    end else begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      if (i_start) begin
        r_cnt <= eff_interval(i_interval);
      end else if (w_tick && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_top.sv
// Main/side-street traffic light controller with pedestrian walk phase.
// Lamps decode the registered state; debug strobes are 1-cycle pulses held low in reset.
module traffic_light_top
  import tlc_pkg::*;
#(
  parameter int         DIV     = 2,
  parameter logic [3:0] T_BASE0 = T_BASE_DEF,
  parameter logic [3:0] T_EXT0  = T_EXT_DEF,
  parameter logic [3:0] T_YEL0  = T_YEL_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       reprogram,
  input  logic [1:0] time_param_selector,
  input  logic [3:0] time_value,
  input  logic       time_val,
  output logic       Rm,
  output logic       Ym,
  output logic       Gm,
  output logic       Rs,
  output logic       Ys,
  output logic       Gs,
  output logic       W,
  output logic       st_state,
  output logic       expired_state,
  output logic       enable_state
);

  tlc_state_t r_state;
  tlc_state_t w_state_nxt;
  logic       r_st;
  logic       w_st_nxt;
  logic       r_walk;
  logic [3:0] r_t_base;
  logic [3:0] r_t_ext;
  logic [3:0] r_t_yel;
  logic [3:0] w_interval;
  logic       w_tick;
  logic       w_expired;
  logic       w_unused;

  assign w_unused      = time_val;
  assign st_state      = r_st && !reset;
  assign enable_state  = w_tick;
  assign expired_state = w_expired;

  // Only sampled on the start cycle, so MG_EXT sees the sensor as it was on entry.
  always_comb begin
    w_interval = r_t_base;
    case (r_state)
      MG_BASE: w_interval = r_t_base;
      MG_EXT:  w_interval = sensor ? r_t_ext : r_t_base;
      MY:      w_interval = r_t_yel;
      WALK:    w_interval = r_t_ext;
      SG:      w_interval = r_t_base;
      SG_EXT:  w_interval = r_t_ext;
      SY:      w_interval = r_t_yel;
      default: w_interval = r_t_base;
    endcase
  end

  tlc_timer #(
    .DIV(DIV)
  ) u_timer (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_start   (st_state),
    .i_interval(w_interval),
    .o_tick    (w_tick),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_st_nxt    = 1'b0;
    if (reprogram) begin
      w_state_nxt = MG_BASE;
      w_st_nxt    = 1'b1;
    end else if (w_expired) begin
      w_st_nxt = 1'b1;
      case (r_state)
        MG_BASE: w_state_nxt = MG_EXT;
        MG_EXT:  w_state_nxt = MY;
        MY:      w_state_nxt = r_walk ? WALK : SG;
        WALK:    w_state_nxt = SG;
        SG:      w_state_nxt = sensor ? SG_EXT : SY;
        SG_EXT:  w_state_nxt = SY;
        SY:      w_state_nxt = MG_BASE;
        default: w_state_nxt = MG_BASE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= MG_BASE;
      r_st     <= 1'b1;
      r_walk   <= 1'b0;
      r_t_base <= T_BASE0;
      r_t_ext  <= T_EXT0;
      r_t_yel  <= T_YEL0;
    end else begin
      r_state <= w_state_nxt;
      r_st    <= w_st_nxt;
      // A fresh press wins over the clear on WALK entry.
      if (walk_request) begin
        r_walk <= 1'b1;
      end else if (st_state && (r_state == WALK)) begin
        r_walk <= 1'b0;
      end
      if (reprogram) begin
        case (time_param_selector)
          SEL_BASE: r_t_base <= time_value;
          SEL_EXT:  r_t_ext  <= time_value;
          SEL_YEL:  r_t_yel  <= time_value;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    Rm = 1'b0;
    Ym = 1'b0;
    Gm = 1'b0;
    Rs = 1'b0;
    Ys = 1'b0;
    Gs = 1'b0;
    W  = 1'b0;
    case (r_state)
      MG_BASE, MG_EXT: begin
        Gm = 1'b1;
        Rs = 1'b1;
      end
      MY: begin
        Ym = 1'b1;
        Rs = 1'b1;
      end
      WALK: begin
        Rm = 1'b1;
        Rs = 1'b1;
        W  = 1'b1;
      end
      SG, SG_EXT: begin
        Rm = 1'b1;
        Gs = 1'b1;
      end
      SY: begin
        Rm = 1'b1;
        Ys = 1'b1;
      end
      default: begin
        Gm = 1'b1;
        Rs = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_top.sv
// Directed bench: walks the controller through fixed phase tables and checks lamps
// and strobes every cycle against hand-computed durations (DIV=2).
module tb_traffic_light_top;

  localparam logic [6:0] L_MG = 7'b0011000;  // {Rm,Ym,Gm,Rs,Ys,Gs,W}
  localparam logic [6:0] L_MY = 7'b0101000;
  localparam logic [6:0] L_WK = 7'b1001001;
  localparam logic [6:0] L_SG = 7'b1000010;
  localparam logic [6:0] L_SY = 7'b1000100;

  logic       clock;
  logic       reset;
  logic       sensor;
  logic       walk_request;
  logic       reprogram;
  logic [1:0] time_param_selector;
  logic [3:0] time_value;
  logic       time_val;
  logic       Rm, Ym, Gm, Rs, Ys, Gs, W;
  logic       st_state, expired_state, enable_state;
  logic [6:0] lamp_vec;

  int n_err;
  int n_chk;
  int cyc;

  assign lamp_vec = {Rm, Ym, Gm, Rs, Ys, Gs, W};

  traffic_light_top #(
    .DIV    (2),
    .T_BASE0(4'd6),
    .T_EXT0 (4'd3),
    .T_YEL0 (4'd2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .sensor             (sensor),
    .walk_request       (walk_request),
    .reprogram          (reprogram),
    .time_param_selector(time_param_selector),
    .time_value         (time_value),
    .time_val           (time_val),
    .Rm                 (Rm),
    .Ym                 (Ym),
    .Gm                 (Gm),
    .Rs                 (Rs),
    .Ys                 (Ys),
    .Gs                 (Gs),
    .W                  (W),
    .st_state           (st_state),
    .expired_state      (expired_state),
    .enable_state       (enable_state)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One phase of n cycles with constant lamps; head/tail mark the state's first/last cycle.
  task automatic run_phase(input string name, input logic [6:0] lamps_exp, input int n,
                           input bit head, input bit tail);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_eq($sformatf("%s lamps c%0d", name, i), 32'(lamp_vec), 32'(lamps_exp));
      check_eq($sformatf("%s st c%0d", name, i), 32'(st_state), 32'(head && (i == 0)));
      check_eq($sformatf("%s expired c%0d", name, i), 32'(expired_state),
               32'(tail && (i == n - 1)));
      check_eq($sformatf("%s tick c%0d", name, i), 32'(enable_state), 32'(cyc[0]));
      cyc++;
    end
  endtask

  task automatic check_quiet(input string name, input logic [6:0] lamps_exp);
    @(negedge clock);
    check_eq({name, " lamps"}, 32'(lamp_vec), 32'(lamps_exp));
    check_eq({name, " st"}, 32'(st_state), 32'd0);
    check_eq({name, " expired"}, 32'(expired_state), 32'd0);
    check_eq({name, " tick"}, 32'(enable_state), 32'd0);
  endtask

  initial begin
    n_err               = 0;
    n_chk               = 0;
    cyc                 = 0;
    reset               = 1'b1;
    sensor              = 1'b0;
    walk_request        = 1'b0;
    reprogram           = 1'b0;
    time_param_selector = 2'd3;
    time_value          = 4'd0;
    time_val            = 1'b0;

    repeat (5) @(posedge clock);
    check_quiet("reset", L_MG);
    @(posedge clock);
    #1 reset = 1'b0;

    // Default cycle with no side traffic.
    run_phase("t1 MG_BASE", L_MG, 12, 1, 1);
    run_phase("t1 MG_EXT", L_MG, 12, 1, 1);
    run_phase("t1 MY", L_MY, 4, 1, 1);
    run_phase("t1 SG", L_SG, 12, 1, 1);
    run_phase("t1 SY", L_SY, 4, 1, 1);

    // Side-street sensor held high.
    @(posedge clock);
    #1 sensor = 1'b1;
    run_phase("t2 MG_BASE", L_MG, 12, 1, 1);
    run_phase("t2 MG_EXT", L_MG, 6, 1, 1);
    run_phase("t2 MY", L_MY, 4, 1, 1);
    run_phase("t2 SG", L_SG, 12, 1, 1);
    run_phase("t2 SG_EXT", L_SG, 6, 1, 1);
    run_phase("t2 SY", L_SY, 4, 1, 1);

    // One-cycle walk press during MG_BASE.
    @(posedge clock);
    #1 sensor = 1'b0;
    run_phase("t3 MG_BASE a", L_MG, 3, 1, 0);
    @(posedge clock);
    #1 walk_request = 1'b1;
    run_phase("t3 MG_BASE b", L_MG, 1, 0, 0);
    @(posedge clock);
    #1 walk_request = 1'b0;
    run_phase("t3 MG_BASE c", L_MG, 8, 0, 1);
    run_phase("t3 MG_EXT", L_MG, 12, 1, 1);
    run_phase("t3 MY", L_MY, 4, 1, 1);
    run_phase("t3 WALK", L_WK, 6, 1, 1);
    run_phase("t3 SG", L_SG, 12, 1, 1);
    run_phase("t3 SY", L_SY, 4, 1, 1);
    run_phase("t3 MG_BASE 2", L_MG, 12, 1, 1);
    run_phase("t3 MG_EXT 2", L_MG, 12, 1, 1);
    run_phase("t3 MY 2", L_MY, 4, 1, 1);
    run_phase("t3 SG no walk", L_SG, 12, 1, 1);
    run_phase("t3 SY 2", L_SY, 4, 1, 1);

    // tYEL <= 0 (runs as 1 s), restart mid MG_BASE.
    run_phase("t4 MG_BASE a", L_MG, 3, 1, 0);
    @(posedge clock);
    #1 begin
      reprogram           = 1'b1;
      time_param_selector = 2'd2;
      time_value          = 4'd0;
    end
    run_phase("t4 reprog", L_MG, 1, 0, 0);
    @(posedge clock);
    #1 reprogram = 1'b0;
    run_phase("t4 MG_BASE", L_MG, 12, 1, 1);
    run_phase("t4 MG_EXT", L_MG, 12, 1, 1);
    run_phase("t4 MY", L_MY, 2, 1, 1);
    run_phase("t4 SG", L_SG, 12, 1, 1);
    run_phase("t4 SY", L_SY, 2, 1, 1);

    // tBASE <= 4.
    run_phase("t5 MG_BASE a", L_MG, 1, 1, 0);
    @(posedge clock);
    #1 begin
      reprogram           = 1'b1;
      time_param_selector = 2'd0;
      time_value          = 4'd4;
    end
    run_phase("t5 reprog", L_MG, 1, 0, 0);
    @(posedge clock);
    #1 reprogram = 1'b0;
    run_phase("t5 MG_BASE", L_MG, 8, 1, 1);
    run_phase("t5 MG_EXT", L_MG, 8, 1, 1);
    run_phase("t5 MY", L_MY, 2, 1, 1);
    run_phase("t5 SG", L_SG, 8, 1, 1);
    run_phase("t5 SY", L_SY, 2, 1, 1);

    // Selector 3: restart only, intervals untouched.
    run_phase("t5s3 MG_BASE a", L_MG, 1, 1, 0);
    @(posedge clock);
    #1 begin
      reprogram           = 1'b1;
      time_param_selector = 2'd3;
      time_value          = 4'd9;
    end
    run_phase("t5s3 reprog", L_MG, 1, 0, 0);
    @(posedge clock);
    #1 reprogram = 1'b0;
    run_phase("t5s3 MG_BASE", L_MG, 8, 1, 1);
    run_phase("t5s3 MG_EXT", L_MG, 8, 1, 1);
    run_phase("t5s3 MY", L_MY, 2, 1, 1);

    // Reset asserted in SG on a tick cycle; intervals must return to defaults.
    run_phase("t6 SG pre", L_SG, 5, 1, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    check_quiet("t6 reset cycle", L_SG);
    check_quiet("t6 after reset", L_MG);
    @(posedge clock);
    #1 begin
      reset = 1'b0;
      cyc   = 0;
    end
    run_phase("t6 MG_BASE", L_MG, 12, 1, 1);
    run_phase("t6 MG_EXT", L_MG, 12, 1, 1);
    run_phase("t6 MY", L_MY, 4, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
